// File: rtl/dmem_pkg.sv
// dmem_pkg: size codes, FSM states and byte-enable helper for sized_data_memory
package dmem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_e;
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} state_e;
  function automatic logic [3:0] byte_en(size_e size, logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a :
           size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store lane replication, byte enables, load extraction/extension, alignment check
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] wrep,
  output logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [31:0] sh;
  always_comb begin
    sh = word >> {a, 3'b000};
    wrep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    be = byte_en(size, a);
    rdata = size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
            size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : word;
    misaligned = size == SZ_BAD || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  end
endmodule

// File: rtl/sized_data_memory.sv
// sized_data_memory: MEM-stage data memory with sized accesses, wait states and valid/ready handshake
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    ADDR_W      = 32,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              stall
);
  localparam int AW = $clog2(DEPTH);
  localparam bit LIVE = WAIT_STATES == 0;
  state_e state;
  logic [3:0] wcnt;
  logic h_write, h_uns;
  size_e h_size;
  logic [ADDR_W-1:0] h_addr;
  logic [31:0] h_wdata;
  logic [31:0] mem [DEPTH];
  logic accept, do_acc, a_write, a_uns, err, mis;
  size_e a_size;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0] a_wdata, wrep, rdata;
  logic [3:0] be;
  logic [AW-1:0] idx;
  assign req_ready = state == DMEM_IDLE;
  assign stall = req_valid & ~req_ready;
  assign accept = req_valid & req_ready & ~rst;
  always_comb begin
    a_write = LIVE ? req_write : h_write;
    a_uns = LIVE ? req_unsigned : h_uns;
    a_size = LIVE ? size_e'(req_size) : h_size;
    a_addr = LIVE ? req_addr : h_addr;
    a_wdata = LIVE ? req_wdata : h_wdata;
    idx = a_addr[AW+1:2];
    err = mis | (|(a_addr >> (AW + 2)));
    do_acc = ~rst & (LIVE ? accept : state == DMEM_WAIT && wcnt == 4'd0);
  end
  dmem_lane_align u_align (
    .size(a_size), .uns(a_uns), .a(a_addr[1:0]), .wdata(a_wdata), .word(mem[idx]),
    .wrep(wrep), .be(be), .rdata(rdata), .misaligned(mis)
  );
  initial
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
  always_ff @(posedge clk)
    if (do_acc && a_write && !err)
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[idx][8*k +: 8] <= wrep[8*k +: 8];
  always_ff @(posedge clk)
    if (accept) begin
      h_write <= req_write;
      h_uns <= req_unsigned;
      h_size <= size_e'(req_size);
      h_addr <= req_addr;
      h_wdata <= req_wdata;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= DMEM_IDLE;
      wcnt <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= do_acc;
      if (do_acc) begin
        resp_rdata <= (a_write || err) ? 32'd0 : rdata;
        resp_error <= err;
      end
      state <= do_acc ? DMEM_RESP : accept ? DMEM_WAIT : state == DMEM_RESP ? DMEM_IDLE : state;
      if (accept && !LIVE) wcnt <= 4'(WAIT_STATES - 1);
      else if (state == DMEM_WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
    end
endmodule

// File: tb/tb_sized_data_memory.sv
// tb_sized_data_memory: directed tests on a zero-wait and a three-wait-state instance
module tb_sized_data_memory;
  logic clk = 1'b0, rst = 1'b1, v0 = 1'b0, v3 = 1'b0;
  logic req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b10;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic r0, rv0, er0, st0, r3, rv3, er3, st3;
  logic [31:0] rd0, rd3;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sized_data_memory #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_error(er0), .stall(st0));
  sized_data_memory #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_error(er3), .stall(st3));

  task automatic op(input logic s, input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] ad, input logic [31:0] wd,
                    output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = ad; req_wdata = wd;
    if (s) v3 = 1'b1; else v0 = 1'b1;
    while (!(s ? r3 : r0) && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    v0 = 1'b0; v3 = 1'b0; lat = 0; rd = 32'hx; er = 1'bx;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      if (s ? rv3 : rv0) begin lat = i; rd = s ? rd3 : rd0; er = s ? er3 : er0; end
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic er; int lat;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", r0); end
    total++; if (rv0 !== 1'b0 || rv3 !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b/%b exp=0", rv0, rv3); end
    total++; if (rd0 !== 32'd0 || er0 !== 1'b0) begin bad++; $display("FAIL reset_resp got=%h/%b exp=0/0", rd0, er0); end
    op(0, 0, 2'b10, 0, 32'h10, 0, rd, er, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL init_lw_latency got=%0d exp=1", lat); end
    total++; if (rd !== 32'h4 || er !== 1'b0) begin bad++; $display("FAIL init_lw got=%h/%b exp=00000004/0", rd, er); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int lat;
    op(0, 1, 2'b10, 0, 32'h40, 32'h11223344, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
    op(0, 1, 2'b00, 0, 32'h41, 32'h000000AA, rd, er, lat);
    op(0, 0, 2'b10, 0, 32'h40, 0, rd, er, lat);
    total++; if (rd !== 32'h1122AA44) begin bad++; $display("FAIL sb_lw got=%h exp=1122aa44", rd); end
    op(0, 0, 2'b00, 0, 32'h41, 0, rd, er, lat);
    total++; if (rd !== 32'hFFFFFFAA) begin bad++; $display("FAIL lb got=%h exp=ffffffaa", rd); end
    op(0, 0, 2'b00, 1, 32'h41, 0, rd, er, lat);
    total++; if (rd !== 32'h000000AA) begin bad++; $display("FAIL lbu got=%h exp=000000aa", rd); end
    op(0, 0, 2'b00, 0, 32'h40, 0, rd, er, lat);
    total++; if (rd !== 32'h00000044) begin bad++; $display("FAIL lb_pos got=%h exp=00000044", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er; int lat;
    op(0, 1, 2'b01, 0, 32'h82, 32'h12348001, rd, er, lat);
    op(0, 0, 2'b01, 0, 32'h82, 0, rd, er, lat);
    total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%h exp=ffff8001", rd); end
    op(0, 0, 2'b01, 1, 32'h82, 0, rd, er, lat);
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu got=%h exp=00008001", rd); end
    op(0, 0, 2'b10, 0, 32'h80, 0, rd, er, lat);
    total++; if (rd !== 32'h80010020) begin bad++; $display("FAIL sh_lw got=%h exp=80010020", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    op(0, 0, 2'b10, 0, 32'h42, 0, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b1 || lat !== 1) begin bad++; $display("FAIL err_lw42 got=%h/%b/%0d exp=0/1/1", rd, er, lat); end
    op(0, 1, 2'b01, 0, 32'h83, 32'h0000FFFF, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b1) begin bad++; $display("FAIL err_sh83 got=%h/%b exp=0/1", rd, er); end
    op(0, 0, 2'b10, 0, 32'h80, 0, rd, er, lat);
    total++; if (rd !== 32'h80010020) begin bad++; $display("FAIL err_sh83_word got=%h exp=80010020", rd); end
    op(0, 1, 2'b11, 0, 32'h40, 32'hDEADBEEF, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b1) begin bad++; $display("FAIL err_size11 got=%h/%b exp=0/1", rd, er); end
    op(0, 0, 2'b10, 0, 32'h40, 0, rd, er, lat);
    total++; if (rd !== 32'h1122AA44) begin bad++; $display("FAIL err_size11_word got=%h exp=1122aa44", rd); end
    op(0, 0, 2'b10, 0, 32'h1000, 0, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b1) begin bad++; $display("FAIL err_range_lw got=%h/%b exp=0/1", rd, er); end
    op(0, 1, 2'b10, 0, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_range_sw got=%b exp=1", er); end
    op(0, 0, 2'b10, 0, 32'h0, 0, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL err_range_word0 got=%h/%b exp=0/0", rd, er); end
  endtask

  task automatic test_back_to_back;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h14; v3 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      total++; if (r3 !== 1'b1 || st3 !== 1'b0) begin bad++; $display("FAIL ws_ready_c0 req%0d got=%b/%b exp=1/0", r, r3, st3); end
      @(posedge clk); #1;
      req_addr = 32'h18;
      for (int c = 1; c <= 4; c++) begin
        total++; if (r3 !== 1'b0 || st3 !== 1'b1) begin bad++; $display("FAIL ws_busy req%0d c%0d got=%b/%b exp=0/1", r, c, r3, st3); end
        total++; if (rv3 !== (c == 4)) begin bad++; $display("FAIL ws_resp_valid req%0d c%0d got=%b exp=%b", r, c, rv3, c == 4); end
        if (c < 4) begin @(posedge clk); #1; end
      end
      total++; if (rd3 !== (r == 0 ? 32'd5 : 32'd6)) begin bad++; $display("FAIL ws_rdata req%0d got=%h exp=%h", r, rd3, r == 0 ? 32'd5 : 32'd6); end
      @(posedge clk); #1;
    end
    v3 = 1'b0;
  endtask

  task automatic test_wait_store_load;
    logic [31:0] rd; logic er; int lat;
    op(1, 1, 2'b10, 0, 32'h24, 32'h12345678, rd, er, lat);
    total++; if (lat !== 4 || er !== 1'b0) begin bad++; $display("FAIL ws_sw got=%0d/%b exp=4/0", lat, er); end
    op(1, 0, 2'b10, 0, 32'h24, 0, rd, er, lat);
    total++; if (rd !== 32'h12345678 || lat !== 4) begin bad++; $display("FAIL ws_lw got=%h/%0d exp=12345678/4", rd, lat); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic er; int lat; logic seen;
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0; seen = rv3;
    @(posedge clk); #1;
    rst = 1'b1; seen |= rv3;
    @(posedge clk); #1;
    rst = 1'b0; seen |= rv3;
    total++; if (r3 !== 1'b1 || rd3 !== 32'd0) begin bad++; $display("FAIL rstw_ready got=%b/%h exp=1/0", r3, rd3); end
    @(posedge clk); #1;
    seen |= rv3;
    total++; if (seen !== 1'b0 || r3 !== 1'b1) begin bad++; $display("FAIL rstw_no_resp got=%b/%b exp=0/1", seen, r3); end
    op(1, 0, 2'b10, 0, 32'h20, 0, rd, er, lat);
    total++; if (rd !== 32'd8 || lat !== 4) begin bad++; $display("FAIL rstw_word got=%h/%0d exp=00000008/4", rd, lat); end
  endtask

  initial begin
    test_reset;
    test_byte;
    test_half;
    test_errors;
    test_back_to_back;
    test_wait_store_load;
    test_reset_in_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
